// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared ids, latency bound and read-return tag for the BRAM port arbiter.
package bram_arb_pkg;
  localparam logic REQ_ID_R0 = 1'b0;
  localparam logic REQ_ID_R1 = 1'b1;
  localparam int MAX_RD_LATENCY = 4;
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register of read-return tags with synchronous clear.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t [DEPTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = rst ? '0 : tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = rst ? '0 : pipe_q[i-1];
  end
  always_ff @(posedge clk) pipe_q <= pipe_d;
  assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between two requesters and routes read data back by id.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed r0-first priority; round-robin otherwise.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              r0_valid_in,
  output logic              r0_ready_out,
  input  logic              r0_we_in,
  input  logic [ADDR_W-1:0] r0_addr_in,
  input  logic [DATA_W-1:0] r0_data_in,
  output logic              r0_rvalid_out,
  output logic [DATA_W-1:0] r0_rdata_out,
  input  logic              r1_valid_in,
  output logic              r1_ready_out,
  input  logic              r1_we_in,
  input  logic [ADDR_W-1:0] r1_addr_in,
  input  logic [DATA_W-1:0] r1_data_in,
  output logic              r1_rvalid_out,
  output logic [DATA_W-1:0] r1_rdata_out,
  output logic              bram_en_out,
  output logic              bram_we_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [DATA_W-1:0] bram_din_out,
  output logic              bram_regce_out,
  output logic              bram_rst_out,
  input  logic [DATA_W-1:0] bram_dout_in
);
  // out-of-range latencies clamp to the supported window
  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
  logic    gnt0, gnt1;
  rd_tag_t push_tag, ret_tag;
`ifdef BRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = !rst_in && r0_valid_in;
    gnt1 = !rst_in && r1_valid_in && !r0_valid_in;
  end
`else
  logic last_grant_q, last_grant_d;
  always_comb begin
    gnt0 = !rst_in && r0_valid_in && (!r1_valid_in || last_grant_q == REQ_ID_R1);
    gnt1 = !rst_in && r1_valid_in && !gnt0;
    last_grant_d = rst_in ? REQ_ID_R1 : gnt0 ? REQ_ID_R0 : gnt1 ? REQ_ID_R1 : last_grant_q;
  end
  always_ff @(posedge clk_in) last_grant_q <= last_grant_d;
`endif
  assign r0_ready_out   = gnt0;
  assign r1_ready_out   = gnt1;
  assign bram_en_out    = gnt0 | gnt1;
  assign bram_we_out    = gnt0 ? r0_we_in : gnt1 ? r1_we_in : 1'b0;
  assign bram_addr_out  = gnt0 ? r0_addr_in : gnt1 ? r1_addr_in : '0;
  assign bram_din_out   = gnt0 ? r0_data_in : gnt1 ? r1_data_in : '0;
  assign bram_regce_out = 1'b1;
  assign bram_rst_out   = rst_in;
  // writes still occupy a slot so returns stay aligned to the BRAM pipeline
  always_comb begin
    push_tag.valid = bram_en_out && !bram_we_out;
    push_tag.id    = gnt1 ? REQ_ID_R1 : REQ_ID_R0;
  end
  rd_tag_pipe #(.DEPTH(LAT)) u_tag_pipe (
    .clk    (clk_in),
    .rst    (rst_in),
    .tag_in (push_tag),
    .tag_out(ret_tag)
  );
  assign r0_rvalid_out = !rst_in && ret_tag.valid && ret_tag.id == REQ_ID_R0;
  assign r1_rvalid_out = !rst_in && ret_tag.valid && ret_tag.id == REQ_ID_R1;
  assign r0_rdata_out  = r0_rvalid_out ? bram_dout_in : '0;
  assign r1_rdata_out  = r1_rvalid_out ? bram_dout_in : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter at read latency 2 and 1 with a cycle-level model.
module tb_bram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 18;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  typedef struct {int due; logic id; logic [DW-1:0] d;} ret_t;
  typedef struct {int cyc; logic id; logic [DW-1:0] d;} ev_t;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_data = '0, r1_data = '0;

  logic r0_ready_a, r1_ready_a, r0_rvalid_a, r1_rvalid_a, en_a, we_a, regce_a, brst_a;
  logic r0_ready_b, r1_ready_b, r0_rvalid_b, r1_rvalid_b, en_b, we_b, regce_b, brst_b;
  logic [DW-1:0] r0_rdata_a, r1_rdata_a, din_a, dout_a, r0_rdata_b, r1_rdata_b, din_b, dout_b;
  logic [AW-1:0] addr_a, addr_b;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut_a (
    .clk_in(clk), .rst_in(rst),
    .r0_valid_in(r0_valid), .r0_ready_out(r0_ready_a), .r0_we_in(r0_we), .r0_addr_in(r0_addr),
    .r0_data_in(r0_data), .r0_rvalid_out(r0_rvalid_a), .r0_rdata_out(r0_rdata_a),
    .r1_valid_in(r1_valid), .r1_ready_out(r1_ready_a), .r1_we_in(r1_we), .r1_addr_in(r1_addr),
    .r1_data_in(r1_data), .r1_rvalid_out(r1_rvalid_a), .r1_rdata_out(r1_rdata_a),
    .bram_en_out(en_a), .bram_we_out(we_a), .bram_addr_out(addr_a), .bram_din_out(din_a),
    .bram_regce_out(regce_a), .bram_rst_out(brst_a), .bram_dout_in(dout_a)
  );

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_b (
    .clk_in(clk), .rst_in(rst),
    .r0_valid_in(r0_valid), .r0_ready_out(r0_ready_b), .r0_we_in(r0_we), .r0_addr_in(r0_addr),
    .r0_data_in(r0_data), .r0_rvalid_out(r0_rvalid_b), .r0_rdata_out(r0_rdata_b),
    .r1_valid_in(r1_valid), .r1_ready_out(r1_ready_b), .r1_we_in(r1_we), .r1_addr_in(r1_addr),
    .r1_data_in(r1_data), .r1_rvalid_out(r1_rvalid_b), .r1_rdata_out(r1_rdata_b),
    .bram_en_out(en_b), .bram_we_out(we_b), .bram_addr_out(addr_b), .bram_din_out(din_b),
    .bram_regce_out(regce_b), .bram_rst_out(brst_b), .bram_dout_in(dout_b)
  );

  // read-first BRAM models, one per DUT, latency 2 and 1
  logic [DW-1:0] mem_a [1024] = '{default: '0};
  logic [DW-1:0] mem_b [1024] = '{default: '0};
  logic [DW-1:0] pa0 = '0, pa1 = '0, pb0 = '0;
  always @(posedge clk) begin
    if (en_a) begin
      pa0 <= mem_a[addr_a];
      if (we_a) mem_a[addr_a] <= din_a;
    end
    pa1 <= pa0;
    if (en_b) begin
      pb0 <= mem_b[addr_b];
      if (we_b) mem_b[addr_b] <= din_b;
    end
  end
  assign dout_a = pa1;
  assign dout_b = pb0;

  req_t q0[$], q1[$];
  ret_t ra[$], rb[$];
  ev_t glog[$], rva[$], rvb[$];
  logic [DW-1:0] mdl_mem [1024] = '{default: '0};
  logic m_last = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic g0, g1, e_we, ea_v, ea_id, eb_v, eb_id;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, ea_d, eb_d;
  logic [DW-1:0] t2d [6] = '{18'h0A0, 18'h140, 18'h0B0, 18'h150, 18'h0C0, 18'h160};
  logic [DW-1:0] t6d [4] = '{18'h0, 18'h0, 18'h0, 18'h11};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_dut(input string s, input logic rdy0, rdy1, en, we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din, input logic regce, brst, rv0, input logic [DW-1:0] rd0,
                         input logic rv1, input logic [DW-1:0] rd1, input logic ev, eid,
                         input logic [DW-1:0] ed);
    chk({s, ".r0_ready"}, 32'(rdy0), 32'(g0));
    chk({s, ".r1_ready"}, 32'(rdy1), 32'(g1));
    chk({s, ".bram_en"}, 32'(en), 32'(g0 | g1));
    chk({s, ".bram_we"}, 32'(we), 32'(e_we));
    chk({s, ".bram_addr"}, 32'(addr), 32'(e_addr));
    chk({s, ".bram_din"}, 32'(din), 32'(e_din));
    chk({s, ".bram_regce"}, 32'(regce), 32'd1);
    chk({s, ".bram_rst"}, 32'(brst), 32'(rst));
    chk({s, ".r0_rvalid"}, 32'(rv0), 32'(ev && !eid));
    chk({s, ".r0_rdata"}, 32'(rd0), (ev && !eid) ? 32'(ed) : 32'd0);
    chk({s, ".r1_rvalid"}, 32'(rv1), 32'(ev && eid));
    chk({s, ".r1_rdata"}, 32'(rd1), (ev && eid) ? 32'(ed) : 32'd0);
  endtask

  // model: decides grants from the arbitration rule and schedules each read's return
  always @(negedge clk) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
    g0 = !rst && r0_valid;
`else
    g0 = !rst && r0_valid && (!r1_valid || m_last);
`endif
    g1 = !rst && r1_valid && !g0;
    e_we = g0 ? r0_we : g1 ? r1_we : 1'b0;
    e_addr = g0 ? r0_addr : g1 ? r1_addr : '0;
    e_din = g0 ? r0_data : g1 ? r1_data : '0;
    ea_v = !rst && ra.size() > 0 && ra[0].due == cyc;
    ea_id = ea_v ? ra[0].id : 1'b0;
    ea_d = ea_v ? ra[0].d : '0;
    eb_v = !rst && rb.size() > 0 && rb[0].due == cyc;
    eb_id = eb_v ? rb[0].id : 1'b0;
    eb_d = eb_v ? rb[0].d : '0;
    cmp_dut("lat2", r0_ready_a, r1_ready_a, en_a, we_a, addr_a, din_a, regce_a, brst_a,
            r0_rvalid_a, r0_rdata_a, r1_rvalid_a, r1_rdata_a, ea_v, ea_id, ea_d);
    cmp_dut("lat1", r0_ready_b, r1_ready_b, en_b, we_b, addr_b, din_b, regce_b, brst_b,
            r0_rvalid_b, r0_rdata_b, r1_rvalid_b, r1_rdata_b, eb_v, eb_id, eb_d);
    if (r0_ready_a) glog.push_back('{cyc, 1'b0, '0});
    if (r1_ready_a) glog.push_back('{cyc, 1'b1, '0});
    if (r0_rvalid_a) rva.push_back('{cyc, 1'b0, r0_rdata_a});
    if (r1_rvalid_a) rva.push_back('{cyc, 1'b1, r1_rdata_a});
    if (r0_rvalid_b) rvb.push_back('{cyc, 1'b0, r0_rdata_b});
    if (r1_rvalid_b) rvb.push_back('{cyc, 1'b1, r1_rdata_b});
    if (ea_v) void'(ra.pop_front());
    if (eb_v) void'(rb.pop_front());
    if (rst) begin
      ra.delete();
      rb.delete();
      m_last = 1'b1;
    end else if (g0 || g1) begin
      if (e_we) mdl_mem[e_addr] = e_din;
      else begin
        ra.push_back('{cyc + 2, g1, mdl_mem[e_addr]});
        rb.push_back('{cyc + 1, g1, mdl_mem[e_addr]});
      end
      m_last = g1;
      if (g0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
    cyc++;
  end

  task automatic drive();
    r0_valid = q0.size() > 0;
    r1_valid = q1.size() > 0;
    {r0_we, r0_addr, r0_data} = '0;
    {r1_we, r1_addr, r1_data} = '0;
    if (q0.size() > 0) {r0_we, r0_addr, r0_data} = {q0[0].we, q0[0].addr, q0[0].data};
    if (q1.size() > 0) {r1_we, r1_addr, r1_data} = {q1[0].we, q1[0].addr, q1[0].data};
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    drive();
    @(posedge clk); #1;
    rst = 0;
    glog.delete();
    rva.delete();
    rvb.delete();
    drive();
  endtask

  task automatic run(input int extra);
    int guard = 0;
    @(negedge clk); #1;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 100) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk); #1;
      guard++;
    end
    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    repeat (extra) begin
      @(posedge clk); #1;
      drive();
    end
  endtask

  task automatic chk_grants(input string nm, input int n, input logic [7:0] ids);
    chk({nm, ".grant_count"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < glog.size() && i < n; i++)
      chk($sformatf("%s.grant%0d", nm, i), 32'(glog[i].id), 32'(ids[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // write then read back at latency 2 and 1
    q0.push_back('{1'b1, 10'd5, 18'h2A});
    q0.push_back('{1'b0, 10'd5, 18'h0});
    do_reset();
    run(4);
    chk_grants("t1", 2, 8'b00);
    chk("t1.rv_count_lat2", 32'(rva.size()), 32'd1);
    chk("t1.rv_count_lat1", 32'(rvb.size()), 32'd1);
    if (rva.size() == 1 && glog.size() == 2) begin
      chk("t1.rv_id", 32'(rva[0].id), 32'd0);
      chk("t1.rv_data", 32'(rva[0].d), 32'h2A);
      chk("t1.rv_delay_lat2", 32'(rva[0].cyc - glog[1].cyc), 32'd2);
    end
    if (rvb.size() == 1 && glog.size() == 2)
      chk("t1.rv_delay_lat1", 32'(rvb[0].cyc - glog[1].cyc), 32'd1);

    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b1, AW'(10 + i), DW'((10 + i) << 4)});
      q1.push_back('{1'b1, AW'(20 + i), DW'((20 + i) << 4)});
    end
    do_reset();
    run(2);

    // contention on every cycle alternates and returns in grant order
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b0, AW'(10 + i), '0});
      q1.push_back('{1'b0, AW'(20 + i), '0});
    end
    do_reset();
    run(4);
    chk_grants("t2", 6, 8'b101010);
    chk("t2.rv_count", 32'(rva.size()), 32'd6);
    for (int i = 0; i < rva.size() && i < 6; i++) begin
      chk($sformatf("t2.rv%0d_id", i), 32'(rva[i].id), 32'(i % 2));
      chk($sformatf("t2.rv%0d_data", i), 32'(rva[i].d), 32'(t2d[i]));
      chk($sformatf("t2.rv%0d_cycle", i), 32'(rva[i].cyc - rva[0].cyc), 32'(i));
    end

    // write and read to the same address pending through reset
    q0.push_back('{1'b1, 10'd3, 18'h11});
    q1.push_back('{1'b0, 10'd3, 18'h0});
    do_reset();
    run(4);
    chk_grants("t3", 2, 8'b10);
    chk("t3.rv_count", 32'(rva.size()), 32'd1);
    if (rva.size() == 1) begin
      chk("t3.rv_id", 32'(rva[0].id), 32'd1);
      chk("t3.rv_data", 32'(rva[0].d), 32'h11);
    end

    // reset the cycle after a read accept drops the return
    do_reset();
    q1.push_back('{1'b0, 10'd5, 18'h0});
    @(posedge clk); #1;
    drive();
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    drive();
    @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk);
    chk_grants("t4", 1, 8'b1);
    chk("t4.rv_count_lat2", 32'(rva.size()), 32'd0);
    chk("t4.rv_count_lat1", 32'(rvb.size()), 32'd0);

    // sustained r0 pressure with a single r1 read
    for (int i = 0; i < 5; i++) q0.push_back('{1'b0, AW'(i), '0});
    q1.push_back('{1'b0, 10'd5, '0});
    do_reset();
    run(4);
`ifdef BRAM_ARB_FIXED_PRIO_EN
    chk_grants("t5", 6, 8'b100000);
`else
    chk_grants("t5", 6, 8'b000010);
`endif

    // back-to-back reads at latency 1
    for (int i = 0; i < 4; i++) q0.push_back('{1'b0, AW'(i), '0});
    do_reset();
    run(3);
    chk_grants("t6", 4, 8'b0000);
    chk("t6.rv_count", 32'(rvb.size()), 32'd4);
    for (int i = 0; i < rvb.size() && i < 4 && glog.size() > 0; i++) begin
      chk($sformatf("t6.rv%0d_cycle", i), 32'(rvb[i].cyc - glog[0].cyc), 32'(i + 1));
      chk($sformatf("t6.rv%0d_data", i), 32'(rvb[i].d), 32'(t6d[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
